lc4_fetch_queue: RTL and testbench

LC4_FETCH_QUEUE -- requirements
Module: lc4_fetch_queue

---
 rtl/lc4_fetch_queue.sv | 88 ++++++++
 tb/tb_lc4_fetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lc4_fetch_queue.sv
// LC4 instruction fetch queue: fetches one word per cycle into a circular buffer
// and presents the two oldest {pc, insn} entries to a dual-issue stage.
module lc4_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h8200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    output logic [15:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic [15:0] i_imem_data,
    output logic        o_a_valid,
    output logic [15:0] o_a_pc,
    output logic [15:0] o_a_insn,
    output logic        o_b_valid,
    output logic [15:0] o_b_pc,
    output logic [15:0] o_b_insn,
    input  logic [1:0]  i_pop,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic [3:0]  o_count
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [15:0]   r_pc_mem   [DEPTH];
    logic [15:0]   r_insn_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [3:0]    r_count;
    logic [15:0]   r_fetch_pc;

    logic          w_push;
    logic [1:0]    w_pop_req;
    logic [1:0]    w_pop_eff;
    logic [AW-1:0] w_b_idx;

    // Handshake: o_imem_req acts as a valid with no back-pressure; the memory must
    // return i_imem_data for o_imem_addr in the same cycle, and the word is taken
    // on any gwe edge where o_imem_req is high. i_pop is trusted up to count.
    assign o_imem_req  = (r_count < DEPTH_C) && !i_redirect;
    assign o_imem_addr = r_fetch_pc;
    assign w_push      = gwe && o_imem_req;

    assign w_pop_req = (i_pop == 2'd3) ? 2'd2 : i_pop;
    assign w_pop_eff = (r_count < {2'b00, w_pop_req}) ? r_count[1:0] : w_pop_req;
    assign w_b_idx   = r_head + AW'(1);

    assign o_count   = r_count;
    assign o_a_valid = (r_count != 4'd0);
    assign o_b_valid = (r_count >= 4'd2);
    assign o_a_pc    = o_a_valid ? r_pc_mem[r_head]    : 16'h0000;
    assign o_a_insn  = o_a_valid ? r_insn_mem[r_head]  : 16'h0000;
    assign o_b_pc    = o_b_valid ? r_pc_mem[w_b_idx]   : 16'h0000;
    assign o_b_insn  = o_b_valid ? r_insn_mem[w_b_idx] : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= 16'h0000;
                r_insn_mem[i] <= 16'h0000;
            end
        end else if (gwe) begin
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= 4'd0;
            end else begin
                if (w_push) begin
                    r_pc_mem[r_tail]   <= r_fetch_pc;
                    r_insn_mem[r_tail] <= i_imem_data;
                    r_tail             <= r_tail + AW'(1);
                    r_fetch_pc         <= r_fetch_pc + 16'd1;
                end
                // Push eligibility came from the start-of-cycle count, so a full
                // queue that drains this cycle still skips the push.
                r_head  <= r_head + AW'(w_pop_eff);
                r_count <= r_count + {3'b000, w_push} - {2'b00, w_pop_eff};
            end
        end
    end
endmodule

// File: tb/tb_lc4_fetch_queue.sv
// Self-checking bench for lc4_fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_lc4_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h8200;

    logic        clk;
    logic        rst;
    logic        gwe;
    logic [15:0] o_imem_addr;
    logic        o_imem_req;
    logic [15:0] i_imem_data;
    logic        o_a_valid;
    logic [15:0] o_a_pc;
    logic [15:0] o_a_insn;
    logic        o_b_valid;
    logic [15:0] o_b_pc;
    logic [15:0] o_b_insn;
    logic [1:0]  i_pop;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic [3:0]  o_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_pc;

    lc4_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .gwe          (gwe),
        .o_imem_addr  (o_imem_addr),
        .o_imem_req   (o_imem_req),
        .i_imem_data  (i_imem_data),
        .o_a_valid    (o_a_valid),
        .o_a_pc       (o_a_pc),
        .o_a_insn     (o_a_insn),
        .o_b_valid    (o_b_valid),
        .o_b_pc       (o_b_pc),
        .o_b_insn     (o_b_insn),
        .i_pop        (i_pop),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_count      (o_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] insn_of(input logic [15:0] pc);
        return 16'h1000 + {12'h000, pc[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = RESET_PC;
    endtask

    task automatic model_update(input logic [1:0] pop, input logic redir, input logic [15:0] rpc);
        int n;
        int p;
        bit do_push;
        n = exp_q.size();
        if (redir) begin
            exp_q.delete();
            m_pc = rpc;
        end else begin
            do_push = (n < DEPTH);
            p = (pop == 2'd3) ? 2 : int'(pop);
            if (p > n) p = n;
            repeat (p) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({m_pc, insn_of(m_pc)});
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic check_outputs();
        int n;
        logic [15:0] ea_pc, ea_insn, eb_pc, eb_insn;
        n = exp_q.size();
        ea_pc = 16'h0; ea_insn = 16'h0; eb_pc = 16'h0; eb_insn = 16'h0;
        if (n >= 1) begin ea_pc = exp_q[0][31:16]; ea_insn = exp_q[0][15:0]; end
        if (n >= 2) begin eb_pc = exp_q[1][31:16]; eb_insn = exp_q[1][15:0]; end
        check("imem_req",  32'(o_imem_req),  32'((n < DEPTH) && !i_redirect));
        check("imem_addr", 32'(o_imem_addr), 32'(m_pc));
        check("count",     32'(o_count),     32'(n));
        check("a_valid",   32'(o_a_valid),   32'(n >= 1));
        check("a_pc",      32'(o_a_pc),      32'(ea_pc));
        check("a_insn",    32'(o_a_insn),    32'(ea_insn));
        check("b_valid",   32'(o_b_valid),   32'(n >= 2));
        check("b_pc",      32'(o_b_pc),      32'(eb_pc));
        check("b_insn",    32'(o_b_insn),    32'(eb_insn));
    endtask

    // driver: one cycle of stimulus, checked mid-cycle before the rising edge
    task automatic step(input logic [1:0] pop, input logic redir, input logic [15:0] rpc,
                        input logic g);
        gwe           = g;
        i_pop         = pop;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_data   = insn_of(m_pc);
        #1;
        check_outputs();
        @(posedge clk);
        if (g) model_update(pop, redir, rpc);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; gwe = 1'b0; i_pop = 2'd0; i_redirect = 1'b0;
        i_redirect_pc = 16'h0; i_imem_data = 16'h0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // fill from reset
        repeat (4) step(2'd0, 1'b0, 16'h0, 1'b1);
        check("fill_count", 32'(o_count),  32'd4);
        check("fill_req",   32'(o_imem_req), 32'd0);
        check("fill_a",     {o_a_pc, o_a_insn}, 32'h8200_1000);
        check("fill_b",     {o_b_pc, o_b_insn}, 32'h8201_1001);
        step(2'd0, 1'b0, 16'h0, 1'b1);

        // full queue pops two: no push that cycle, resumes next
        step(2'd2, 1'b0, 16'h0, 1'b1);
        check("full_pop_count", 32'(o_count),     32'd2);
        check("full_pop_a_pc",  32'(o_a_pc),      32'h8202);
        check("full_pop_addr",  32'(o_imem_addr), 32'h8204);
        step(2'd0, 1'b0, 16'h0, 1'b1);
        check("resume_count", 32'(o_count), 32'd3);

        // redirect overrides pop and push
        step(2'd2, 1'b1, 16'h0040, 1'b1);
        check("redir_count", 32'(o_count),     32'd0);
        check("redir_addr",  32'(o_imem_addr), 32'h0040);
        step(2'd0, 1'b0, 16'h0, 1'b1);
        check("redir_first", {o_a_pc, o_a_insn}, 32'h0040_1000);

        // count 1 with pop 2 and push: count stays 1
        step(2'd2, 1'b0, 16'h0, 1'b1);
        check("pop_clip_count", 32'(o_count), 32'd1);
        check("pop_clip_a_pc",  32'(o_a_pc),  32'h0041);

        // PC wrap through 16'hFFFF
        step(2'd0, 1'b1, 16'hFFFE, 1'b1);
        repeat (3) step(2'd0, 1'b0, 16'h0, 1'b1);
        check("wrap_a_pc", 32'(o_a_pc), 32'hFFFE);
        check("wrap_b_pc", 32'(o_b_pc), 32'hFFFF);
        step(2'd2, 1'b0, 16'h0, 1'b1);
        check("wrap_zero", 32'(o_a_pc), 32'h0000);

        // gwe low freezes everything
        repeat (3) step(2'd2, 1'b1, 16'h1234, 1'b0);
        check("gwe_count", 32'(o_count),     32'd2);
        check("gwe_addr",  32'(o_imem_addr), 32'h0002);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                               : 16'($urandom);
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0), rpc,
                 ($urandom_range(0, 9) != 0));
        end

        // asynchronous reset mid-cycle
        gwe = 1'b1; i_pop = 2'd2;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("areset_count", 32'(o_count),   32'd0);
        check("areset_valid", {30'd0, o_a_valid, o_b_valid}, 32'd0);
        check("areset_slot",  {o_a_pc, o_b_insn}, 32'd0);
        check("areset_addr",  32'(o_imem_addr), 32'(RESET_PC));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2'd0, 1'b0, 16'h0, 1'b1);
        check("post_reset_a", {o_a_pc, o_a_insn}, 32'h8200_1000);
        for (int i = 0; i < 40; i++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 16'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
